// File: rtl/mix4_gain_sequencer.sv
// mix4_gain_sequencer: frame-driven 4x stereo gain/mix sequencer with one shared MAC and saturated output
//   CLK, RST_N (async active-low)
//   in_valid, in1_L..in4_R    : sample strobe and eight signed BIT-wide samples
//   cfg_we/addr/gain/mute     : per-input gain (unsigned Q1.(GBIT-1)) and mute register writes
//   clr_flags                 : synchronous clear of sticky flags
//   out_L/out_R, out_valid    : saturated mix, one-cycle valid pulse
//   busy, overrun, sat_flag   : frame in progress, dropped strobe (sticky), clipped result (sticky)
//   Optional SOFT_RAMP_EN     : shadow gains step 1 LSB per frame toward target (0 when muted)
module mix4_gain_sequencer #(
  parameter int BIT      = 24,
  parameter int GBIT     = 8,
  parameter int GAIN_RST = 128
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   in_valid,
  input  logic signed [BIT-1:0]  in1_L,
  input  logic signed [BIT-1:0]  in1_R,
  input  logic signed [BIT-1:0]  in2_L,
  input  logic signed [BIT-1:0]  in2_R,
  input  logic signed [BIT-1:0]  in3_L,
  input  logic signed [BIT-1:0]  in3_R,
  input  logic signed [BIT-1:0]  in4_L,
  input  logic signed [BIT-1:0]  in4_R,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_addr,
  input  logic [GBIT-1:0]        cfg_gain,
  input  logic                   cfg_mute,
  input  logic                   clr_flags,
  output logic signed [BIT-1:0]  out_L,
  output logic signed [BIT-1:0]  out_R,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   overrun,
  output logic                   sat_flag
);
  localparam int ACCW = BIT + GBIT + 2;
  localparam logic [1:0] IDLE = 2'd0, MAC = 2'd1, DONE = 2'd2;
  localparam logic signed [ACCW-1:0] HI = {{(GBIT+3){1'b0}}, {(BIT-1){1'b1}}};
  localparam logic signed [ACCW-1:0] LO = ~HI;
  localparam logic [GBIT-1:0] GR = GBIT'(GAIN_RST);
  logic [1:0] state;
  logic [2:0] idx;
  logic signed [BIT-1:0] smp [8];
  logic signed [BIT-1:0] din [8];
  logic [GBIT-1:0] g [4];
  logic [GBIT-1:0] sg [4];
  logic m [4];
  logic sm [4];
  logic signed [ACCW-1:0] acc_l, acc_r, mul, shr, prod;
  logic signed [BIT-1:0] cl_l, cl_r;
  logic cap, sat_l, sat_r;
  assign din = '{in1_L, in1_R, in2_L, in2_R, in3_L, in3_R, in4_L, in4_R};
  assign cap = in_valid && (state == IDLE || state == DONE);
  assign busy = state != IDLE;
  // shift kept separate so it stays arithmetic (floor toward -inf)
  assign mul = ACCW'(smp[idx]) * ACCW'($signed({1'b0, sg[idx[2:1]]}));
  assign shr = mul >>> (GBIT - 1);
  assign prod = sm[idx[2:1]] ? '0 : shr;
  assign sat_l = acc_l > HI || acc_l < LO;
  assign sat_r = acc_r > HI || acc_r < LO;
  assign cl_l = acc_l > HI ? HI[BIT-1:0] : acc_l < LO ? LO[BIT-1:0] : acc_l[BIT-1:0];
  assign cl_r = acc_r > HI ? HI[BIT-1:0] : acc_r < LO ? LO[BIT-1:0] : acc_r[BIT-1:0];
`ifdef SOFT_RAMP_EN
  logic [GBIT-1:0] tgt [4];
  always_comb
    for (int i = 0; i < 4; i++) tgt[i] = m[i] ? '0 : g[i];
`endif
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      idx <= '0;
      acc_l <= '0;
      acc_r <= '0;
      out_L <= '0;
      out_R <= '0;
      out_valid <= 1'b0;
      overrun <= 1'b0;
      sat_flag <= 1'b0;
      for (int i = 0; i < 8; i++) smp[i] <= '0;
      for (int i = 0; i < 4; i++) begin
        g[i] <= GR;
        sg[i] <= GR;
        m[i] <= 1'b0;
        sm[i] <= 1'b0;
      end
    end else begin
      out_valid <= 1'b0;
      if (cfg_we) begin
        g[cfg_addr] <= cfg_gain;
        m[cfg_addr] <= cfg_mute;
      end
      if (state == MAC) begin
        if (idx[0]) acc_r <= acc_r + prod;
        else acc_l <= acc_l + prod;
        idx <= idx + 3'd1;
        if (idx == 3'd7) state <= DONE;
      end
      if (state == DONE) begin
        out_L <= cl_l;
        out_R <= cl_r;
        out_valid <= 1'b1;
      end
      if (cap) begin
        for (int i = 0; i < 8; i++) smp[i] <= din[i];
        for (int i = 0; i < 4; i++) begin
`ifdef SOFT_RAMP_EN
          sg[i] <= sg[i] < tgt[i] ? sg[i] + GBIT'(1) : sg[i] > tgt[i] ? sg[i] - GBIT'(1) : sg[i];
          sm[i] <= 1'b0;
`else
          sg[i] <= g[i];
          sm[i] <= m[i];
`endif
        end
        acc_l <= '0;
        acc_r <= '0;
        idx <= '0;
        state <= MAC;
      end else if (state == DONE) state <= IDLE;
      // a set in the same cycle as clr_flags wins
      overrun <= (in_valid && state == MAC) || (overrun && !clr_flags);
      sat_flag <= (state == DONE && (sat_l || sat_r)) || (sat_flag && !clr_flags);
    end
  end
endmodule

// File: tb/tb_mix4_gain_sequencer.sv
// tb_mix4_gain_sequencer: directed self-checking bench for mix4_gain_sequencer
module tb_mix4_gain_sequencer;
  logic CLK, RST_N, in_valid, cfg_we, cfg_mute, clr_flags;
  logic signed [23:0] in1_L, in1_R, in2_L, in2_R, in3_L, in3_R, in4_L, in4_R;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_gain;
  logic signed [23:0] out_L, out_R;
  logic out_valid, busy, overrun, sat_flag;
  int n_chk = 0;
  int n_fail = 0;
  int lat, cnt, t1, t2;

  mix4_gain_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid),
    .in1_L(in1_L), .in1_R(in1_R), .in2_L(in2_L), .in2_R(in2_R),
    .in3_L(in3_L), .in3_R(in3_R), .in4_L(in4_L), .in4_R(in4_R),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_gain(cfg_gain), .cfg_mute(cfg_mute),
    .clr_flags(clr_flags), .out_L(out_L), .out_R(out_R), .out_valid(out_valid),
    .busy(busy), .overrun(overrun), .sat_flag(sat_flag)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int a, input int b, input int c, input int d,
                        input int e, input int f, input int g, input int h);
    in1_L = 24'(a); in1_R = 24'(b); in2_L = 24'(c); in2_R = 24'(d);
    in3_L = 24'(e); in3_R = 24'(f); in4_L = 24'(g); in4_R = 24'(h);
  endtask

  task automatic cfg(input int a, input int gn, input logic mu);
    cfg_addr = 2'(a); cfg_gain = 8'(gn); cfg_mute = mu; cfg_we = 1'b1;
    @(posedge CLK); #1;
    cfg_we = 1'b0;
  endtask

  task automatic frame(input int wcyc, output int l);
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    l = -1;
    for (int c = 1; c <= 20 && l < 0; c++) begin
      cfg_we = (c == wcyc);
      @(posedge CLK); #1;
      cfg_we = 1'b0;
      if (out_valid) l = c;
    end
  endtask

  task automatic strobes(input int gap, output int n, output int a, output int b);
    n = 0; a = -1; b = -1;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    for (int c = 1; c <= 22; c++) begin
      in_valid = (c == gap);
      @(posedge CLK); #1;
      if (out_valid) begin
        n++;
        if (a < 0) a = c;
        else b = c;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; in_valid = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_gain = '0;
    cfg_mute = 1'b0; clr_flags = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_out_L", out_L, 0);
    chk("rst_out_R", out_R, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_sat", sat_flag, 0);
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;

    set_in(1000, 7, -200, 7, 50, 7, 0, 7);
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    chk("busy_after_strobe", busy, 1);
    lat = -1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(posedge CLK); #1;
      if (out_valid) lat = c;
    end
    chk("t1_latency", lat, 9);
    chk("t1_out_L", out_L, 850);
    chk("t1_out_R", out_R, 28);
    chk("t1_sat", sat_flag, 0);
    @(posedge CLK); #1;
    chk("t1_pulse_one_cycle", out_valid, 0);
    chk("t1_busy_idle", busy, 0);
    chk("t1_hold_L", out_L, 850);

    cfg(0, 64, 1'b0);
    cfg(1, 128, 1'b1);
    set_in(1001, -2001, 5000, 5000, 0, 0, 0, 0);
    frame(0, lat);
    chk("t2_latency", lat, 9);
    chk("t2_out_L", out_L, 500);
    chk("t2_out_R_floor", out_R, -1001);
    cfg(0, 128, 1'b0);
    cfg(1, 128, 1'b0);

    set_in(8388607, -8388608, 8388607, -8388608, 8388607, -8388608, 8388607, -8388608);
    frame(0, lat);
    chk("t3_latency", lat, 9);
    chk("t3_out_L_clip", out_L, 8388607);
    chk("t3_out_R_clip", out_R, -8388608);
    chk("t3_sat_set", sat_flag, 1);
    clr_flags = 1'b1;
    @(posedge CLK); #1;
    clr_flags = 1'b0;
    chk("t3_sat_clr", sat_flag, 0);

    set_in(10, 20, 0, 0, 0, 0, 0, 0);
    strobes(4, cnt, t1, t2);
    chk("t4_overrun_set", overrun, 1);
    chk("t4_overrun_count", cnt, 1);
    chk("t4_overrun_time", t1, 9);
    chk("t4_overrun_L", out_L, 10);
    clr_flags = 1'b1;
    @(posedge CLK); #1;
    clr_flags = 1'b0;
    chk("t4_overrun_clr", overrun, 0);
    strobes(9, cnt, t1, t2);
    chk("t4_b2b_count", cnt, 2);
    chk("t4_b2b_first", t1, 9);
    chk("t4_b2b_second", t2, 18);
    chk("t4_b2b_no_overrun", overrun, 0);

    set_in(100, 0, 0, 0, 0, 0, 0, 0);
    cfg_addr = 2'd0; cfg_gain = 8'd0; cfg_mute = 1'b0;
    frame(3, lat);
    chk("t5_latency", lat, 9);
    chk("t5_shadow_L", out_L, 100);
    frame(0, lat);
    chk("t5_next_L", out_L, 0);

    set_in(0, 0, 400, 0, 0, 0, 0, 0);
    frame(0, lat);
    chk("t6_pre_L", out_L, 400);
    set_in(300, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    chk("t6_busy_before_rst", busy, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("t6_rst_out_L", out_L, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_valid", out_valid, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST_N = 1'b1;
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge CLK); #1;
      if (out_valid) cnt++;
    end
    chk("t6_no_valid_after_abort", cnt, 0);
    frame(0, lat);
    chk("t6_post_latency", lat, 9);
    chk("t6_post_gain_reset_L", out_L, 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
